instruction_queue: RTL and testbench



---
 rtl/rv32i_types.sv | 13 +
 rtl/instruction_queue.sv | 85 ++++++++
 tb/tb_instruction_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types between fetch, instruction queue and scoreboard issue logic.
// Carries the decoded-fetch entry layout and the default queue depth.
package rv32i_types;

  localparam int DEFAULT_IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] order;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// In-order instruction queue, fetch -> scoreboard, FWFT head, one-cycle flush; stats under IQ_STATS_EN.
// Latency: an entry enqueued into an empty queue is visible on iq_data the next cycle.
// Backpressure: enq_ready = !full from registered state only; no pass-through while full.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = DEFAULT_IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  input  iq_entry_t                enq_data,
  output logic                     enq_ready,
  output iq_entry_t                iq_data,
  output logic                     iq_empty,
  input  logic                     iq_deq,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic [31:0]              stat_full_stall,
  output logic [$clog2(DEPTH):0]   stat_max_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  iq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            enq_fire;
  logic            deq_fire;

  assign iq_empty  = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign enq_ready = !full;
  assign iq_count  = wr_ptr - rd_ptr;

  // Flush wins over both events, so the entry offered during a flush is dropped.
  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = iq_deq && !iq_empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never cleared; stale contents are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

  assign iq_data = iq_empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef IQ_STATS_EN
  logic [31:0]   full_stall_q;
  logic [PW-1:0] max_occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_stall_q <= '0;
      max_occ_q    <= '0;
    end else begin
      if (enq_valid && !enq_ready && !flush && (full_stall_q != '1))
        full_stall_q <= full_stall_q + 32'd1;
      if (iq_count > max_occ_q)
        max_occ_q <= iq_count;
    end
  end

  assign stat_full_stall = full_stall_q;
  assign stat_max_occ    = max_occ_q;
`else
  assign stat_full_stall = '0;
  assign stat_max_occ    = '0;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a queue-based scoreboard of expected entries.
module tb_instruction_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enq_valid;
  iq_entry_t         enq_data;
  logic              enq_ready;
  iq_entry_t         iq_data;
  logic              iq_empty;
  logic              iq_deq;
  logic              flush;
  logic [3:0]        iq_count;
  logic [31:0]       stat_full_stall;
  logic [3:0]        stat_max_occ;

  int checks = 0;
  int errors = 0;

  iq_entry_t   exp_q[$];
  int          m_stall;
  int          m_max;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .iq_data(iq_data), .iq_empty(iq_empty), .iq_deq(iq_deq),
    .flush(flush), .iq_count(iq_count),
    .stat_full_stall(stat_full_stall), .stat_max_occ(stat_max_occ)
  );

  function automatic iq_entry_t mk(input int ord);
    iq_entry_t e;
    e.pc    = 32'h0000_1000 + 32'(ord) * 32'd4;
    e.inst  = 32'hdead_0000 ^ 32'(ord);
    e.order = 32'(ord);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance model and DUT by one clock.
  task automatic step(input logic v, input int ord, input logic d, input logic f);
    int n;
    enq_valid = v;
    enq_data  = mk(ord);
    iq_deq    = d;
    flush     = f;
    n = exp_q.size();
    chk("enq_ready", 128'(enq_ready), 128'(n != DEPTH));
    chk("iq_empty",  128'(iq_empty),  128'(n == 0));
    chk("iq_count",  128'(iq_count),  128'(n));
    chk("iq_data",   128'(iq_data),   (n == 0) ? 128'd0 : 128'(exp_q[0]));
`ifdef IQ_STATS_EN
    chk("stat_full_stall", 128'(stat_full_stall), 128'(m_stall));
    chk("stat_max_occ",    128'(stat_max_occ),    128'(m_max));
    if (v && n == DEPTH && !f) m_stall++;
    if (n > m_max) m_max = n;
`else
    chk("stat_full_stall", 128'(stat_full_stall), 128'd0);
    chk("stat_max_occ",    128'(stat_max_occ),    128'd0);
`endif
    if (f) exp_q.delete();
    else begin
      if (d && n > 0) void'(exp_q.pop_front());
      if (v && n < DEPTH) exp_q.push_back(mk(ord));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_data = '0; iq_deq = 1'b0; flush = 1'b0;
    m_stall = 0; m_max = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Three enqueues without dequeue; head appears one cycle after the first.
    step(1'b1, 1, 1'b0, 1'b0);
    chk("head_after_first", 128'(iq_data.order), 128'd1);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    chk("count3", 128'(iq_count), 128'd3);

    // Fill to DEPTH with enq_valid held high, then stall offering order 9.
    for (int i = 4; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    chk("full_ready", 128'(enq_ready), 128'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 9, 1'b0, 1'b0);
    chk("count_full", 128'(iq_count), 128'd8);

    // Full with enq and deq together: only the dequeue happens.
    step(1'b1, 9, 1'b1, 1'b0);
    chk("full_deq_count", 128'(iq_count), 128'd7);
    step(1'b1, 9, 1'b0, 1'b0);
    chk("refill_count", 128'(iq_count), 128'd8);

    // Drain; scoreboard confirms 2..9 with nothing extra written.
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);
    chk("drained_empty", 128'(iq_empty), 128'd1);

    // Streaming: one primed entry, then 20 concurrent enq/deq wrapping the pointers.
    step(1'b1, 1, 1'b0, 1'b0);
    for (int i = 2; i <= 21; i++) begin
      chk("stream_head", 128'(iq_data.order), 128'(i - 1));
      step(1'b1, i, 1'b1, 1'b0);
    end
    chk("stream_count", 128'(iq_count), 128'd1);
    step(1'b0, 0, 1'b1, 1'b0);

    // Flush with five entries held while fetch offers another.
    for (int i = 30; i < 35; i++) step(1'b1, i, 1'b0, 1'b0);
    chk("pre_flush_count", 128'(iq_count), 128'd5);
    step(1'b1, 99, 1'b0, 1'b1);
    chk("flush_empty", 128'(iq_empty), 128'd1);
    chk("flush_data", 128'(iq_data), 128'd0);
    idle();
    chk("flush_dropped", 128'(iq_count), 128'd0);

    // Dequeue on empty is ignored; the next entry still lands at the head.
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("empty_deq_count", 128'(iq_count), 128'd0);
    step(1'b1, 40, 1'b0, 1'b0);
    chk("after_empty_deq", 128'(iq_data.order), 128'd40);
    step(1'b1, 41, 1'b0, 1'b0);
    step(1'b1, 42, 1'b0, 1'b0);

    // Asynchronous reset between clock edges while holding entries.
    enq_valid = 1'b0; iq_deq = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", 128'(iq_empty), 128'd1);
    chk("async_rst_count", 128'(iq_count), 128'd0);
    exp_q.delete();
    m_stall = 0;
    m_max = 0;
    #1 rst_n = 1'b1;
    idle();
    step(1'b1, 50, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
